// File: rtl/pdm_decim_ctrl.sv
`timescale 1ns/1ps
// pdm_decim_ctrl: microphone front-end sequencer.
// Generates the PDM mic clock, samples the one-bit mic stream on each mic-clock
// rising edge, feeds the FIR filter with full-scale 8-bit samples, and
// decimates the filter output stream into audio samples. The first group of
// filter outputs after each enable is discarded to flush the filter history.
module pdm_decim_ctrl #(
    parameter int PDM_COUNT_PERIOD = 16,
    parameter int NUM_PDM_SAMPLES  = 128,
    parameter int WIDTH            = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             enable_in,
    input  logic             mic_data_in,
    output logic             mic_clk_out,
    output logic [WIDTH-1:0] fir_audio_out,
    output logic             fir_valid_out,
    input  logic             fir_ready_in,
    input  logic [WIDTH-1:0] fir_data_in,
    input  logic             fir_data_valid_in,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_valid_out,
    output logic [7:0]       overrun_count_out
);

    localparam int CW = $clog2(PDM_COUNT_PERIOD);
    localparam int DW = $clog2(NUM_PDM_SAMPLES);

    localparam logic [CW-1:0] M_LAST      = CW'(PDM_COUNT_PERIOD - 1);
    localparam logic [CW-1:0] M_HALF      = CW'(PDM_COUNT_PERIOD / 2);
    localparam logic [DW-1:0] DCOUNT_LAST = DW'(NUM_PDM_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] m_count;
    logic [DW-1:0] dcount;
    logic          mic_clk_prev;
    logic          running;
    logic          mic_edge;
    logic          last_valid;

    // A disable request takes effect immediately: every running register
    // clears on the same clock edge that moves the FSM back to IDLE.
    assign running    = (state != IDLE) && enable_in;
    assign mic_edge   = mic_clk_out & ~mic_clk_prev;
    assign last_valid = running && fir_data_valid_in && (dcount == DCOUNT_LAST);

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: warmup ends on the last output of the flush group.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable_in) begin
                    state_next = WARMUP;
                end
            end
            WARMUP: begin
                if (!enable_in) begin
                    state_next = IDLE;
                end else if (last_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!enable_in) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Mic clock divider: high for the first half of each period, low for the second.
    always_ff @(posedge clk_in) begin
        if (rst_in || !running) begin
            m_count     <= '0;
            mic_clk_out <= 1'b0;
        end else begin
            m_count     <= (m_count == M_LAST) ? '0 : m_count + CW'(1);
            mic_clk_out <= (m_count < M_HALF);
        end
    end

    // Delayed copy of the mic clock for rising-edge detection.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mic_clk_prev <= 1'b0;
        end else begin
            mic_clk_prev <= mic_clk_out;
        end
    end

    // Filter feed: one strobe per mic edge, or a dropped bit counted as an overrun.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fir_valid_out     <= 1'b0;
            fir_audio_out     <= '0;
            overrun_count_out <= '0;
        end else begin
            fir_valid_out <= running && mic_edge && fir_ready_in;
            if (running && mic_edge && fir_ready_in) begin
                fir_audio_out <= {WIDTH{mic_data_in}};
            end
            if (running && mic_edge && !fir_ready_in && (overrun_count_out != 8'hFF)) begin
                overrun_count_out <= overrun_count_out + 8'd1;
            end
        end
    end

    // Decimator: every Nth filter output becomes an audio sample once warmed up.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dcount           <= '0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
        end else begin
            sample_valid_out <= 1'b0;
            if (!running) begin
                dcount <= '0;
            end else if (fir_data_valid_in) begin
                if (dcount == DCOUNT_LAST) begin
                    dcount <= '0;
                    if (state == RUN) begin
                        sample_out       <= fir_data_in;
                        sample_valid_out <= 1'b1;
                    end
                end else begin
                    dcount <= dcount + DW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_decim_ctrl.sv
`timescale 1ns/1ps
// tb_pdm_decim_ctrl: directed bench with a sample scoreboard for pdm_decim_ctrl.
module tb_pdm_decim_ctrl;

    localparam int P = 16;
    localparam int N = 128;
    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         enable_in;
    logic         mic_data_in;
    logic         mic_clk_out;
    logic [W-1:0] fir_audio_out;
    logic         fir_valid_out;
    logic         fir_ready_in;
    logic [W-1:0] fir_data_in;
    logic         fir_data_valid_in;
    logic [W-1:0] sample_out;
    logic         sample_valid_out;
    logic [7:0]   overrun_count_out;

    typedef struct {
        logic [7:0] data;
        int         cycle;
    } exp_t;

    exp_t       sampleQ[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         mDcount = 0;
    bit         mWarm = 0;
    bit         mEnabled = 1;
    logic [7:0] dataCtr = 8'd0;
    logic [7:0] lastSample = 8'd0;
    int         firSeen = 0;
    logic       micPrev = 1'b0;
    int         relX;
    int         seenAt;
    int         lastAt;

    pdm_decim_ctrl #(
        .PDM_COUNT_PERIOD(P),
        .NUM_PDM_SAMPLES (N),
        .WIDTH           (W)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .enable_in        (enable_in),
        .mic_data_in      (mic_data_in),
        .mic_clk_out      (mic_clk_out),
        .fir_audio_out    (fir_audio_out),
        .fir_valid_out    (fir_valid_out),
        .fir_ready_in     (fir_ready_in),
        .fir_data_in      (fir_data_in),
        .fir_data_valid_in(fir_data_valid_in),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .overrun_count_out(overrun_count_out)
    );

    // Free-running clock and cycle counter.
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Mic stream toggles every 1000 ns, shortly after a rising edge.
    initial begin
        mic_data_in = 1'b0;
        #1007;
        forever begin
            mic_data_in = ~mic_data_in;
            #1000;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: filter feed data against the mic bit of the edge cycle, and
    // audio sample strobes against the scoreboard.
    always @(negedge clk_in) begin
        if (fir_valid_out) begin
            firSeen++;
            checkOutput("fir_audio", {24'd0, fir_audio_out}, {24'd0, {8{micPrev}}});
        end
        micPrev = mic_data_in;
        if (sample_valid_out) begin
            if (sampleQ.size() == 0) begin
                checkOutput("unexpected_sample_strobe", {31'd0, sample_valid_out}, 32'd0);
            end else begin
                exp_t e;
                e = sampleQ.pop_front();
                checkOutput("sample_out", {24'd0, sample_out}, {24'd0, e.data});
                checkOutput("sample_latency", cyc, e.cycle);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic rdy);
        enable_in    = en;
        fir_ready_in = rdy;
    endtask

    // Reference decimator: one call per filter output driven to the DUT.
    task automatic modelValid(input logic [7:0] d);
        if (!mEnabled) return;
        if (mDcount == N - 1) begin
            mDcount = 0;
            if (mWarm) begin
                exp_t e;
                e.data  = d;
                e.cycle = cyc + 1;
                sampleQ.push_back(e);
                lastSample = d;
            end else begin
                mWarm = 1;
            end
        end else begin
            mDcount++;
        end
    endtask

    task automatic sendValids(input int n);
        for (int i = 0; i < n; i++) begin
            fir_data_valid_in = 1'b1;
            fir_data_in       = dataCtr;
            modelValid(dataCtr);
            dataCtr = dataCtr + 8'd1;
            tick(1);
            fir_data_valid_in = 1'b0;
            tick(1);
        end
    endtask

    task automatic enableDut();
        applyStimulus(1'b1, fir_ready_in);
        mEnabled = 1;
        mDcount  = 0;
        mWarm    = 0;
        tick(2);
    endtask

    task automatic disableDut();
        applyStimulus(1'b0, fir_ready_in);
        mEnabled = 0;
        mDcount  = 0;
        mWarm    = 0;
        tick(1);
        @(negedge clk_in);
        checkOutput("disable_mic_clk", {31'd0, mic_clk_out}, 32'd0);
        checkOutput("disable_fir_valid", {31'd0, fir_valid_out}, 32'd0);
        tick(1);
    endtask

    task automatic waitFir(output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (fir_valid_out) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) checkOutput("fir_wait_timeout", {31'd0, fir_valid_out}, 32'd1);
    endtask

    task automatic waitCycle(input int target);
        do begin
            @(negedge clk_in);
        end while (cyc < target);
    endtask

    initial begin
        rst_in            = 1'b1;
        fir_data_valid_in = 1'b0;
        fir_data_in       = 8'd0;
        applyStimulus(1'b1, 1'b1);

        // Reset with enable high: all outputs zero.
        tick(1);
        @(negedge clk_in);
        checkOutput("rst_mic_clk", {31'd0, mic_clk_out}, 32'd0);
        checkOutput("rst_fir_audio", {24'd0, fir_audio_out}, 32'd0);
        checkOutput("rst_fir_valid", {31'd0, fir_valid_out}, 32'd0);
        checkOutput("rst_sample", {24'd0, sample_out}, 32'd0);
        checkOutput("rst_sample_valid", {31'd0, sample_valid_out}, 32'd0);
        checkOutput("rst_overrun", {24'd0, overrun_count_out}, 32'd0);
        tick(1);
        rst_in = 1'b0;
        relX   = cyc;

        // First filter strobe three cycles after reset release.
        waitFir(seenAt);
        checkOutput("first_fir_latency", seenAt - relX, 32'd3);

        // Mic clock 8-high / 8-low pattern, aligned on a rising edge.
        seenAt = -1;
        for (int i = 0; i < 40 && seenAt < 0; i++) begin
            logic was;
            was = mic_clk_out;
            @(negedge clk_in);
            if (mic_clk_out && !was) seenAt = cyc;
        end
        checkOutput("mic_clk_rise_found", {31'd0, mic_clk_out}, 32'd1);
        for (int i = 1; i < 32; i++) begin
            @(negedge clk_in);
            checkOutput("mic_clk_pattern", {31'd0, mic_clk_out}, ((i % 16) < 8) ? 32'd1 : 32'd0);
        end

        // Filter strobe period.
        lastAt = -1;
        for (int k = 0; k < 5; k++) begin
            waitFir(seenAt);
            if (lastAt >= 0) checkOutput("fir_period", seenAt - lastAt, 32'd16);
            lastAt = seenAt;
        end
        tick(1);

        // Decimation: 128 flushed, then strobes at values 255 and 127.
        sendValids(3 * N);
        tick(3);
        checkOutput("decim_q_drained", sampleQ.size(), 32'd0);
        checkOutput("decim_last_sample", {24'd0, sample_out}, 32'd127);

        // Mid-sample disable, ignored valids while idle, then re-enable.
        sendValids(50);
        disableDut();
        sendValids(10);
        tick(2);
        checkOutput("idle_sample_hold", {24'd0, sample_out}, {24'd0, lastSample});
        enableDut();
        sendValids(N);
        tick(3);
        checkOutput("warmup_sample_hold", {24'd0, sample_out}, 32'd127);
        checkOutput("warmup_no_strobe", sampleQ.size(), 32'd0);
        sendValids(N);
        tick(3);
        checkOutput("reenable_q_drained", sampleQ.size(), 32'd0);

        // Disable coinciding with the Nth valid: disable wins.
        sendValids(N - 1);
        fir_data_valid_in = 1'b1;
        fir_data_in       = dataCtr;
        dataCtr           = dataCtr + 8'd1;
        applyStimulus(1'b0, 1'b1);
        mEnabled = 0;
        mDcount  = 0;
        mWarm    = 0;
        tick(1);
        fir_data_valid_in = 1'b0;
        tick(3);
        checkOutput("simul_sample_hold", {24'd0, sample_out}, {24'd0, lastSample});
        checkOutput("simul_mic_clk", {31'd0, mic_clk_out}, 32'd0);

        // Overrun: filter never ready for 300 edges.
        rst_in = 1'b1;
        applyStimulus(1'b1, 1'b0);
        mEnabled = 1;
        mDcount  = 0;
        mWarm    = 0;
        tick(2);
        firSeen = 0;
        rst_in  = 1'b0;
        relX    = cyc;
        waitCycle(relX + 2 + 16 * 9);
        checkOutput("overrun_9", {24'd0, overrun_count_out}, 32'd9);
        waitCycle(relX + 3 + 16 * 9);
        checkOutput("overrun_10", {24'd0, overrun_count_out}, 32'd10);
        waitCycle(relX + 3 + 16 * 254);
        checkOutput("overrun_255", {24'd0, overrun_count_out}, 32'd255);
        waitCycle(relX + 3 + 16 * 299 + 5);
        checkOutput("overrun_saturate", {24'd0, overrun_count_out}, 32'd255);
        checkOutput("overrun_no_fir", firSeen, 32'd0);
        tick(1);
        disableDut();
        tick(2);
        checkOutput("overrun_hold_idle", {24'd0, overrun_count_out}, 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
